// File: rtl/mux_sel_rr_arbiter_pkg.sv
// rtl/mux_sel_rr_arbiter_pkg.sv - shared constants, state type and helpers for the mux select arbiter
package mux_sel_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux_sel_rr_arbiter_if.sv
// rtl/mux_sel_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface mux_sel_rr_arbiter_if;
    import mux_sel_rr_arbiter_pkg::*;

    logic             enable_i;
    logic [N_REQ-1:0] req_i;
    logic             release_i;
    logic [N_REQ-1:0] grant_o;
    logic [SEL_W-1:0] select_o;
    logic             busy_o;
    logic             timeout_o;

    modport master (
        output enable_i, req_i, release_i,
        input  grant_o, select_o, busy_o, timeout_o
    );

    modport slave (
        input  enable_i, req_i, release_i,
        output grant_o, select_o, busy_o, timeout_o
    );

endinterface

// File: rtl/mux_sel_rr_arbiter_rr_pick4.sv
// rtl/mux_sel_rr_arbiter_rr_pick4.sv - combinational rotating-priority picker over four requests
module rr_pick4
    import mux_sel_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from farthest to nearest so the request closest to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// rtl/mux_sel_rr_arbiter.sv - round-robin owner selection for a shared 4:1 data mux
module mux_sel_rr_arbiter
    import mux_sel_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mux_sel_rr_arbiter_if.slave  bus
);

    localparam bit               HAS_LIMIT = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_SAT  = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;

    logic             end_ok;
    logic             end_to;
    logic [N_REQ-1:0] pick_req;
    logic [SEL_W-1:0] pick_ptr;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;

    // A dropped request ends the grant just like an explicit release; the timeout only fires otherwise.
    always_comb begin
        end_ok = bus.release_i | ~bus.req_i[sel_q];
        end_to = HAS_LIMIT && (hold_q == HOLD_LAST) && !end_ok;
    end

    // Feed the single picker: from ptr when idle, from owner+1 at a handover, excluding a released owner.
    always_comb begin
        pick_ptr = ptr_q;
        pick_req = bus.enable_i ? bus.req_i : '0;
        if (state_q == ST_GRANT) begin
            pick_ptr = sel_q + SEL_W'(1);
            if (end_ok) begin
                pick_req = pick_req & ~onehot(sel_q);
            end
        end
    end

    rr_pick4 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        to_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    grant_d = onehot(pick_idx);
                    sel_d   = pick_idx;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (end_ok || end_to) begin
                    ptr_d = sel_q + SEL_W'(1);
                    to_d  = end_to;
                    if (pick_valid) begin
                        grant_d = onehot(pick_idx);
                        sel_d   = pick_idx;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign bus.grant_o   = grant_q;
    assign bus.select_o  = sel_q;
    assign bus.busy_o    = busy_q;
    assign bus.timeout_o = to_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb/tb_mux_sel_rr_arbiter.sv - scoreboard bench for the round-robin mux select arbiter
module tb_mux_sel_rr_arbiter;

    typedef struct {
        int         which;
        int         cyc_at;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       to;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    mux_sel_rr_arbiter_if bus8 ();
    mux_sel_rr_arbiter_if bus0 ();

    mux_sel_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8)
    );

    mux_sel_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: compare queued expectations at the falling edge of the cycle they belong to.
    initial begin
        exp_t e;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc_at <= cyc) begin
                e = sb.pop_front();
                n_checks = n_checks + 1;
                if (e.which == 8) begin
                    g = bus8.grant_o; s = bus8.select_o; b = bus8.busy_o; t = bus8.timeout_o;
                end else begin
                    g = bus0.grant_o; s = bus0.select_o; b = bus0.busy_o; t = bus0.timeout_o;
                end
                if (e.cyc_at != cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: stale entry for cyc %0d seen at cyc %0d", e.name, e.cyc_at, cyc);
                end else if (g !== e.grant || s !== e.sel || b !== e.busy || t !== e.to) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s (dut%0d cyc %0d): got grant=%b sel=%b busy=%b to=%b, expected grant=%b sel=%b busy=%b to=%b",
                             e.name, e.which, cyc, g, s, b, t, e.grant, e.sel, e.busy, e.to);
                end
            end
        end
    end

    task automatic push(input int which, input int at, input logic [3:0] g, input logic [1:0] s,
                        input logic b, input logic t, input string name);
        exp_t e;
        e.which = which; e.cyc_at = at; e.grant = g; e.sel = s; e.busy = b; e.to = t; e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp8(input logic [3:0] g, input logic [1:0] s, input logic b, input logic t, input string name);
        push(8, cyc + 1, g, s, b, t, name);
    endtask

    task automatic exp0(input logic [3:0] g, input logic [1:0] s, input logic b, input logic t, input string name);
        push(0, cyc + 1, g, s, b, t, name);
    endtask

    task automatic set8(input logic en, input logic [3:0] req, input logic rel);
        bus8.enable_i  = en;
        bus8.req_i     = req;
        bus8.release_i = rel;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [3:0] oh;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        set8(1'b1, 4'b0000, 1'b0);
        bus0.enable_i = 1'b1; bus0.req_i = 4'b0000; bus0.release_i = 1'b0;
        tick();
        exp8(4'b0000, 2'b00, 1'b0, 1'b0, "reset8");
        exp0(4'b0000, 2'b00, 1'b0, 1'b0, "reset0");
        tick();
        rst = 1'b0;

        // Test 2: grant from idle, zero-bubble handover, then idle.
        set8(1'b1, 4'b1010, 1'b0); exp8(4'b0010, 2'b01, 1'b1, 1'b0, "t2_grant"); tick();
        set8(1'b1, 4'b1010, 1'b1); exp8(4'b1000, 2'b11, 1'b1, 1'b0, "t2_handover"); tick();
        set8(1'b1, 4'b0000, 1'b1); exp8(4'b0000, 2'b11, 1'b0, 1'b0, "t2_idle"); tick();

        // Test 3: all requesting, release every cycle -> rotation 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) begin
            oh = 4'b0001 << (i % 4);
            set8(1'b1, 4'b1111, 1'b1);
            exp8(oh, 2'(i % 4), 1'b1, 1'b0, "t3_rotate");
            tick();
        end
        set8(1'b1, 4'b0000, 1'b1); exp8(4'b0000, 2'b01, 0, 0, "t3_idle"); tick();

        // Test 4: ptr=2, req 0011 -> owner 0 holds 8 cycles, times out to 1, which times out back to 0.
        set8(1'b1, 4'b0011, 1'b0);
        exp8(4'b0001, 2'b00, 1, 0, "t4_grant0"); tick();
        for (int i = 1; i < 8; i++) begin
            exp8(4'b0001, 2'b00, 1, 0, "t4_hold0"); tick();
        end
        exp8(4'b0010, 2'b01, 1, 1, "t4_timeout0"); tick();
        for (int i = 1; i < 8; i++) begin
            exp8(4'b0010, 2'b01, 1, 0, "t4_hold1"); tick();
        end
        exp8(4'b0001, 2'b00, 1, 1, "t4_timeout1"); tick();
        set8(1'b1, 4'b0000, 1'b0); exp8(4'b0000, 2'b00, 0, 0, "t4_drop"); tick();

        // Test 5: enable gating, dropped request, enable low during a grant.
        for (int i = 0; i < 5; i++) begin
            set8(1'b0, 4'b0100, 1'b0); exp8(4'b0000, 2'b00, 0, 0, "t5_disabled"); tick();
        end
        set8(1'b1, 4'b0100, 1'b0); exp8(4'b0100, 2'b10, 1, 0, "t5_enable"); tick();
        set8(1'b1, 4'b0000, 1'b0); exp8(4'b0000, 2'b10, 0, 0, "t5_drop"); tick();
        set8(1'b1, 4'b0110, 1'b0); exp8(4'b0010, 2'b01, 1, 0, "t5_ptr3_pick1"); tick();
        set8(1'b0, 4'b0110, 1'b1); exp8(4'b0000, 2'b01, 0, 0, "t5_no_handover"); tick();

        // Test 1: owner 2, asynchronous reset between edges, then req 0001 granted one cycle after release.
        set8(1'b1, 4'b0100, 1'b0); exp8(4'b0100, 2'b10, 1, 0, "t1_owner2"); tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        push(8, cyc, 4'b0000, 2'b00, 1'b0, 1'b0, "t1_async_reset");
        tick();
        rst = 1'b0;
        set8(1'b1, 4'b0001, 1'b0); exp8(4'b0001, 2'b00, 1, 0, "t1_after_reset"); tick();
        set8(1'b1, 4'b0000, 1'b0); exp8(4'b0000, 2'b00, 0, 0, "t1_idle"); tick();

        // Test 6: unlimited hold never times out.
        bus0.enable_i = 1'b1; bus0.req_i = 4'b0001; bus0.release_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            exp0(4'b0001, 2'b00, 1, 0, "t6_unlimited"); tick();
        end
        bus0.req_i = 4'b0000;

        tick();
        tick();
        n_checks = n_checks + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
